// File: rtl/ha1588_pkg.sv
// ha1588_pkg: constants and types shared by the PTP timestamp unit.
// Covers GMII framing bytes, PTP encapsulation fields and parser states.
package ha1588_pkg;

    localparam logic [15:0] ETH_PTP      = 16'h88F7;
    localparam logic [15:0] ETH_VLAN     = 16'h8100;
    localparam logic [15:0] ETH_IPV4     = 16'h0800;

    localparam logic [15:0] UDP_PTP_EVT  = 16'd319;
    localparam logic [15:0] UDP_PTP_GEN  = 16'd320;

    localparam logic [7:0]  GMII_PRE     = 8'h55;
    localparam logic [7:0]  GMII_SFD     = 8'hD5;
    localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

    localparam int          K_W          = 7;
    localparam logic [K_W-1:0] K_MAX     = 7'h7F;

    typedef enum logic [1:0] {
        ENC_L2        = 2'd0,
        ENC_L2_VLAN   = 2'd1,
        ENC_IPV4      = 2'd2,
        ENC_IPV4_VLAN = 2'd3
    } encap_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_HDR   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic is_ptp_port(input logic [15:0] port);
        return (port == UDP_PTP_EVT) || (port == UDP_PTP_GEN);
    endfunction

endpackage

// File: rtl/gmii_ptp_parser.sv
// gmii_ptp_parser: flags each GMII start-of-frame and classifies PTP frames.
// Extracts messageType/sequenceId from L2 or IPv4/UDP, optional 802.1Q tag.
module gmii_ptp_parser
    import ha1588_pkg::*;
#(
    parameter bit EN_VLAN = 1'b1,
    parameter bit EN_IPV4 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_ctrl,
    input  logic [7:0]  gmii_data,
    output logic        sof_stb,
    output logic        ptp_stb,
    output logic [3:0]  ptp_msg_type,
    output logic [15:0] ptp_seq_id,
    output logic [1:0]  ptp_encap,
    output logic        abort_stb
);

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic            vlan_q, vlan_d;
    logic            ip_q, ip_d;
    logic [7:0]      prev_q, prev_d;
    logic [3:0]      msg_cap_q, msg_cap_d;
    logic            blk_q, blk_d;
    logic            sof_q, sof_d;
    logic            ptp_q, ptp_d;
    logic            abort_q, abort_d;
    logic [3:0]      msg_q, msg_d;
    logic [15:0]     seq_q, seq_d;
    encap_e          encap_q, encap_d;

    logic [K_W-1:0]  vo;
    logic [K_W-1:0]  p_off;
    logic [K_W-1:0]  k_inc;
    logic [15:0]     fld;

    // Offsets shift by four bytes once a VLAN tag has been seen; the
    // previous byte pairs with the current one to form 16-bit fields.
    assign vo    = vlan_q ? 7'd4 : 7'd0;
    assign p_off = (ip_q ? 7'd42 : 7'd14) + vo;
    assign k_inc = (k_q == K_MAX) ? k_q : k_q + 7'd1;
    assign fld   = {prev_q, gmii_data};

    // Next-state, field compare and output register computation.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        vlan_d    = vlan_q;
        ip_d      = ip_q;
        prev_d    = prev_q;
        msg_cap_d = msg_cap_q;
        blk_d     = blk_q;
        sof_d     = 1'b0;
        ptp_d     = 1'b0;
        abort_d   = 1'b0;
        msg_d     = msg_q;
        seq_d     = seq_q;
        encap_d   = encap_q;

        // A control drop re-arms preamble detection.
        if (!gmii_ctrl) begin
            blk_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (gmii_ctrl) begin
                    if (gmii_data == GMII_PRE && !blk_q) begin
                        state_d = ST_PRE;
                    end else begin
                        blk_d = 1'b1;
                    end
                end
            end

            ST_PRE: begin
                if (!gmii_ctrl) begin
                    state_d = ST_IDLE;
                end else if (gmii_data == GMII_PRE) begin
                    state_d = ST_PRE;
                end else if (gmii_data == GMII_SFD) begin
                    state_d = ST_HDR;
                    sof_d   = 1'b1;
                    k_d     = '0;
                    vlan_d  = 1'b0;
                    ip_d    = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_HDR: begin
                if (!gmii_ctrl) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    k_d    = k_inc;
                    prev_d = gmii_data;
                    unique case (1'b1)
                        (k_q == 7'd13 + vo): begin
                            if (EN_VLAN && !vlan_q && fld == ETH_VLAN) begin
                                vlan_d = 1'b1;
                            end else if (fld == ETH_PTP) begin
                                ip_d = 1'b0;
                            end else if (EN_IPV4 && fld == ETH_IPV4) begin
                                ip_d = 1'b1;
                            end else begin
                                state_d = ST_DRAIN;
                            end
                        end
                        (ip_q && k_q == 7'd14 + vo): begin
                            if (gmii_data != IPV4_VER_IHL) begin
                                state_d = ST_DRAIN;
                            end
                        end
                        (ip_q && k_q == 7'd23 + vo): begin
                            if (gmii_data != IP_PROTO_UDP) begin
                                state_d = ST_DRAIN;
                            end
                        end
                        (ip_q && k_q == 7'd37 + vo): begin
                            if (!is_ptp_port(fld)) begin
                                state_d = ST_DRAIN;
                            end
                        end
                        (k_q == p_off): begin
                            msg_cap_d = gmii_data[3:0];
                        end
                        (k_q == p_off + 7'd31): begin
                            state_d = ST_DRAIN;
                            ptp_d   = 1'b1;
                            msg_d   = msg_cap_q;
                            seq_d   = fld;
                            encap_d = encap_e'({ip_q, vlan_q});
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_DRAIN: begin
                if (!gmii_ctrl) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset blocks preamble until ctrl drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            vlan_q    <= 1'b0;
            ip_q      <= 1'b0;
            prev_q    <= 8'h00;
            msg_cap_q <= 4'h0;
            blk_q     <= 1'b1;
            sof_q     <= 1'b0;
            ptp_q     <= 1'b0;
            abort_q   <= 1'b0;
            msg_q     <= 4'h0;
            seq_q     <= 16'h0000;
            encap_q   <= ENC_L2;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            vlan_q    <= vlan_d;
            ip_q      <= ip_d;
            prev_q    <= prev_d;
            msg_cap_q <= msg_cap_d;
            blk_q     <= blk_d;
            sof_q     <= sof_d;
            ptp_q     <= ptp_d;
            abort_q   <= abort_d;
            msg_q     <= msg_d;
            seq_q     <= seq_d;
            encap_q   <= encap_d;
        end
    end

    assign sof_stb      = sof_q;
    assign ptp_stb      = ptp_q;
    assign abort_stb    = abort_q;
    assign ptp_msg_type = msg_q;
    assign ptp_seq_id   = seq_q;
    assign ptp_encap    = encap_q;

endmodule

// File: tb/tb_gmii_ptp_parser.sv
// tb_gmii_ptp_parser: scoreboard bench for gmii_ptp_parser.
// Two instances (VLAN on/off) share the stimulus; a reference model predicts events.
module tb_gmii_ptp_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gmii_ctrl = 1'b0;
    logic [7:0]  gmii_data = 8'h00;

    logic        sof0, ptp0, abt0, sof1, ptp1, abt1;
    logic [3:0]  msg0, msg1;
    logic [15:0] seq0, seq1;
    logic [1:0]  enc0, enc1;

    gmii_ptp_parser dut (
        .clk(clk), .rst(rst), .gmii_ctrl(gmii_ctrl), .gmii_data(gmii_data),
        .sof_stb(sof0), .ptp_stb(ptp0), .ptp_msg_type(msg0),
        .ptp_seq_id(seq0), .ptp_encap(enc0), .abort_stb(abt0)
    );

    gmii_ptp_parser #(.EN_VLAN(1'b0), .EN_IPV4(1'b1)) dut_nv (
        .clk(clk), .rst(rst), .gmii_ctrl(gmii_ctrl), .gmii_data(gmii_data),
        .sof_stb(sof1), .ptp_stb(ptp1), .ptp_msg_type(msg1),
        .ptp_seq_id(seq1), .ptp_encap(enc1), .abort_stb(abt1)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        int          kind;
        int          cyc;
        logic [3:0]  msg;
        logic [15:0] seq;
        logic [1:0]  enc;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  frm [0:255];
    int          flen;

    logic [3:0]  hmsg [2];
    logic [15:0] hseq [2];
    logic [1:0]  henc [2];
    int last_sof [2];
    int last_ptp [2];
    int cnt_sof [2];
    int cnt_ptp [2];
    int cnt_abt [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int first_of(input int id);
        foreach (sb[i]) if (sb[i].id == id) return i;
        return -1;
    endfunction

    // Reference model: kind 0 none, 1 PTP, 2 abort; d = deciding byte index.
    function automatic void model(input bit ev, output int kind, output int d,
                                  output logic [3:0] m, output logic [15:0] s,
                                  output logic [1:0] e);
        int v, p;
        bit ip;
        logic [15:0] t, pt;
        v = 0; p = -1; ip = 0; kind = 0; m = 0; s = 0; e = 0;
        t = {frm[12], frm[13]};
        d = 13;
        if (ev && t == 16'h8100) begin
            v = 4;
            t = {frm[16], frm[17]};
            d = 17;
        end
        if (t == 16'h88F7) begin
            p = 14 + v;
        end else if (t == 16'h0800) begin
            ip = 1;
            pt = {frm[36+v], frm[37+v]};
            if (frm[14+v] != 8'h45) d = 14 + v;
            else if (frm[23+v] != 8'h11) d = 23 + v;
            else if (pt != 16'd319 && pt != 16'd320) d = 37 + v;
            else p = 42 + v;
        end
        if (p >= 0) begin
            d = p + 31;
            kind = 1;
            m = frm[p][3:0];
            s = {frm[p+30], frm[p+31]};
            e = {ip, (v != 0)};
        end
        if (flen <= d) kind = 2;
    endfunction

    task automatic mon(input int id, input logic sof, input logic ptp,
                       input logic abt, input logic [3:0] m,
                       input logic [15:0] s, input logic [1:0] e);
        int idx, k;
        exp_t x;
        string tg;
        tg = (id == 0) ? "dut" : "dut_nv";
        if (!rst) begin
            hmsg[id] = 0; hseq[id] = 0; henc[id] = 0;
            chk({tg, "_rst_strobes"}, {sof, ptp, abt}, 0);
            chk({tg, "_rst_outputs"}, {m, s, e}, 0);
            return;
        end
        idx = first_of(id);
        while (idx >= 0 && sb[idx].cyc < cyc) begin
            chk({tg, "_missed_event_cycle"}, cyc, sb[idx].cyc);
            sb.delete(idx);
            idx = first_of(id);
        end
        if (sof || ptp || abt) begin
            k = ptp ? 1 : (abt ? 2 : 0);
            chk({tg, "_strobe_onehot"}, $countones({sof, ptp, abt}), 1);
            if (idx < 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_unexpected: strobe kind %0d seen, none expected, cycle %0d",
                         tg, k, cyc);
            end else begin
                x = sb[idx];
                sb.delete(idx);
                chk({tg, "_kind"}, k, x.kind);
                chk({tg, "_cycle"}, cyc, x.cyc);
                if (ptp) begin
                    chk({tg, "_msg"}, m, x.msg);
                    chk({tg, "_seq"}, s, x.seq);
                    chk({tg, "_encap"}, e, x.enc);
                    hmsg[id] = x.msg; hseq[id] = x.seq; henc[id] = x.enc;
                end
            end
            if (sof) begin last_sof[id] = cyc; cnt_sof[id]++; end
            if (ptp) begin last_ptp[id] = cyc; cnt_ptp[id]++; end
            if (abt) cnt_abt[id]++;
        end
        if (!ptp) chk({tg, "_hold"}, {m, s, e}, {hmsg[id], hseq[id], henc[id]});
    endtask

    always @(negedge clk) begin
        mon(0, sof0, ptp0, abt0, msg0, seq0, enc0);
        mon(1, sof1, ptp1, abt1, msg1, seq1, enc1);
    end

    task automatic drv(input logic c, input logic [7:0] d);
        @(negedge clk);
        gmii_ctrl = c;
        gmii_data = d;
    endtask

    task automatic build(input int kind, input bit vlan, input logic [7:0] mb,
                         input logic [15:0] sq, input logic [15:0] dport,
                         input int len);
        int v, p;
        logic [15:0] t;
        for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
        v = vlan ? 4 : 0;
        p = -1;
        if (vlan) begin frm[12] = 8'h81; frm[13] = 8'h00; end
        case (kind)
            0: begin
                {frm[12+v], frm[13+v]} = 16'h88F7;
                p = 14 + v;
            end
            1, 2, 3, 5: begin
                {frm[12+v], frm[13+v]} = 16'h0800;
                frm[14+v] = (kind == 3) ? 8'h46 : 8'h45;
                frm[23+v] = (kind == 5) ? 8'h06 : 8'h11;
                {frm[36+v], frm[37+v]} = (kind == 2) ? 16'h0035 : dport;
                p = 42 + v;
            end
            default: begin
                t = 16'($urandom);
                if (t == 16'h8100 || t == 16'h88F7 || t == 16'h0800) t = 16'h86DD;
                {frm[12+v], frm[13+v]} = t;
            end
        endcase
        if (p >= 0) begin
            frm[p] = mb;
            {frm[p+30], frm[p+31]} = sq;
        end
        if (len >= 0) flen = len;
        else flen = ((p >= 0) ? p + 32 : 60) + $urandom_range(0, 20);
    endtask

    task automatic send(input int npre, input bit bad_sfd, input int ifg,
                        input int rst_at);
        int c0;
        int kd [2];
        int dd [2];
        logic [3:0]  mm [2];
        logic [15:0] ss [2];
        logic [1:0]  ee [2];
        model(1'b1, kd[0], dd[0], mm[0], ss[0], ee[0]);
        model(1'b0, kd[1], dd[1], mm[1], ss[1], ee[1]);
        for (int i = 0; i < npre; i++) drv(1'b1, 8'h55);
        drv(1'b1, bad_sfd ? 8'h5D : 8'hD5);
        c0 = cyc;
        if (!bad_sfd) begin
            for (int id = 0; id < 2; id++) begin
                sb.push_back('{id, 0, c0 + 1, 4'h0, 16'h0, 2'h0});
                if (rst_at < 0 && kd[id] == 1)
                    sb.push_back('{id, 1, c0 + 2 + dd[id], mm[id], ss[id], ee[id]});
                if (rst_at < 0 && kd[id] == 2)
                    sb.push_back('{id, 2, c0 + 2 + flen, 4'h0, 16'h0, 2'h0});
            end
        end
        for (int i = 0; i < flen; i++) begin
            drv(1'b1, frm[i]);
            if (i == rst_at) begin
                #1 rst = 1'b0;
                sb.delete();
            end
            if (rst_at >= 0 && i == rst_at + 3) begin
                #1 rst = 1'b1;
            end
        end
        for (int i = 0; i < ifg; i++) drv(1'b0, 8'($urandom));
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0, a0, s1, p1, a1;
        int kind, len;
        bit vlan;
        logic [15:0] dport;

        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) drv(1'b0, 8'h00);

        // Untagged L2 Sync
        build(0, 0, 8'h00, 16'h1234, 16'h013F, -1);
        send(7, 0, 12, -1);
        settle();
        chk("lat_l2", last_ptp[0] - last_sof[0], 46);

        // VLAN IPv4 Delay_Req; VLAN-disabled instance must not flag it
        p1 = cnt_ptp[1];
        build(1, 1, 8'h01, 16'hBEEF, 16'h013F, -1);
        send(7, 0, 12, -1);
        settle();
        chk("lat_ipv4_vlan", last_ptp[0] - last_sof[0], 78);
        chk("nv_tagged_no_ptp", cnt_ptp[1] - p1, 0);

        // Non-PTP: DNS port, then IHL=6
        s0 = cnt_sof[0]; p0 = cnt_ptp[0]; a0 = cnt_abt[0];
        build(2, 0, 8'h00, 16'h1111, 16'h013F, -1);
        send(7, 0, 12, -1);
        build(3, 0, 8'h00, 16'h2222, 16'h0140, -1);
        send(7, 0, 12, -1);
        settle();
        chk("nonptp_sof", cnt_sof[0] - s0, 2);
        chk("nonptp_ptp", cnt_ptp[0] - p0, 0);
        chk("nonptp_abort", cnt_abt[0] - a0, 0);

        // Truncated L2 PTP at k=30, then a good frame
        a0 = cnt_abt[0]; p0 = cnt_ptp[0];
        build(0, 0, 8'h03, 16'h5555, 16'h013F, 30);
        send(7, 0, 12, -1);
        settle();
        chk("trunc_abort", cnt_abt[0] - a0, 1);
        chk("trunc_no_ptp", cnt_ptp[0] - p0, 0);
        build(0, 0, 8'h02, 16'hA0A0, 16'h013F, -1);
        send(7, 0, 12, -1);
        settle();
        chk("after_trunc_ptp", cnt_ptp[0] - p0, 1);

        // Reset mid-frame at k=20, released with ctrl still high
        s0 = cnt_sof[0]; p0 = cnt_ptp[0]; a0 = cnt_abt[0];
        build(0, 0, 8'h00, 16'h7777, 16'h013F, 70);
        for (int i = 20; i < 70; i++) if (i[0]) frm[i] = 8'h55; else frm[i] = 8'hD5;
        {frm[12], frm[13]} = 16'h88F7;
        send(7, 0, 12, 20);
        settle();
        chk("rst_sof", cnt_sof[0] - s0, 1);
        chk("rst_no_ptp", cnt_ptp[0] - p0, 0);
        chk("rst_no_abort", cnt_abt[0] - a0, 0);

        // Back-to-back with a single idle cycle
        s0 = cnt_sof[0]; p0 = cnt_ptp[0];
        build(0, 0, 8'h00, 16'h0101, 16'h013F, 50);
        send(7, 0, 1, -1);
        build(1, 0, 8'h08, 16'h0202, 16'h0140, 80);
        send(7, 0, 12, -1);
        settle();
        chk("b2b_sof", cnt_sof[0] - s0, 2);
        chk("b2b_ptp", cnt_ptp[0] - p0, 2);

        // Bad SFD: no start-of-frame at all
        s1 = cnt_sof[1]; a1 = cnt_abt[1];
        build(0, 0, 8'h00, 16'h3333, 16'h013F, -1);
        send(5, 1, 6, -1);
        settle();
        chk("badsfd_no_sof", cnt_sof[1] - s1, 0);
        chk("badsfd_no_abort", cnt_abt[1] - a1, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 5);
            vlan  = $urandom_range(0, 1);
            dport = $urandom_range(0, 1) ? 16'h013F : 16'h0140;
            len   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 80) : -1;
            build(kind, vlan, 8'($urandom), 16'($urandom), dport, len);
            send($urandom_range(1, 7), ($urandom_range(0, 15) == 0),
                 $urandom_range(1, 12), -1);
        end

        repeat (20) drv(1'b0, 8'h00);
        settle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
